// File: rtl/fpu_conv_pkg.sv
// Shared constants, lane classification and per-lane stage-1 record for the 16b->64b FP widening converter.
// Combinational helpers only; no state and no flow control live here.
package fpu_conv_pkg;

  localparam int FP64_BIAS = 1023;
  localparam int FP16_BIAS = 15;
  localparam int BF16_BIAS = 127;
  localparam int REBIAS_H  = FP64_BIAS - FP16_BIAS;
  localparam int REBIAS_B  = FP64_BIAS - BF16_BIAS;

  localparam int FLAG_INVALID = 0;
  localparam int FLAG_DENORM  = 1;

  typedef enum logic [2:0] {ZERO, DENORM, NORMAL, INF, NAN} cls_e;

  // Mantissa is kept left-justified in 10 bits so FP16 and BF16 share one normaliser.
  typedef struct packed {
    logic       sign;
    logic       mode;
    logic [7:0] exp;
    logic [9:0] man;
    logic [3:0] lz;
    cls_e       cls;
  } lane_s1_t;

  function automatic logic [3:0] lzc10(input logic [9:0] m);
    logic [3:0] n;
    n = 4'd10;
    for (int i = 0; i < 10; i++) begin
      if (m[i]) n = 4'(9 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fpu_conv_pk_h2d_if.sv
// Beat handshake, data and sticky-flag bundle between the converter and its producer/consumer.
// master drives beats in and accepts results; slave is the converter.
interface fpu_conv_pk_h2d_if #(parameter int LANES = 4);

  logic                  i_valid;
  logic                  i_ready;
  logic                  i_mode;
  logic [16*LANES-1:0]   i_data;
  logic                  o_valid;
  logic                  o_ready;
  logic [64*LANES-1:0]   o_data;
  logic                  flags_clr;
  logic [1:0]            flags;

  modport master (
    output i_valid, i_mode, i_data, o_ready, flags_clr,
    input  i_ready, o_valid, o_data, flags
  );

  modport slave (
    input  i_valid, i_mode, i_data, o_ready, flags_clr,
    output i_ready, o_valid, o_data, flags
  );

endinterface

// File: rtl/fpu_conv_lane_h2d.sv
// One lane: classify + leading-zero count (stage-1 half) and normalise/rebias/pack (stage-2 half).
// Purely combinational; the top owns the registers between the two halves and all backpressure.
module fpu_conv_lane_h2d
  import fpu_conv_pkg::*;
#(
  parameter bit DENORM_FTZ = 1'b0
) (
  input  logic [15:0] raw,
  input  logic        mode,
  output lane_s1_t    s1_d,
  input  lane_s1_t    s1_q,
  output logic [63:0] res,
  output logic        denorm_hit,
  output logic        snan_hit
);

  function automatic lane_s1_t classify(input logic [15:0] x, input logic md);
    lane_s1_t r;
    logic     emax;
    r.sign = x[15];
    r.mode = md;
    if (md) begin
      r.exp = x[14:7];
      r.man = {x[6:0], 3'b000};
      emax  = &x[14:7];
    end else begin
      r.exp = {3'b000, x[14:10]};
      r.man = x[9:0];
      emax  = &x[14:10];
    end
    r.lz = lzc10(r.man);
    if (r.exp == 8'd0)  r.cls = (r.man == 10'd0) ? ZERO : DENORM;
    else if (emax)      r.cls = (r.man == 10'd0) ? INF : NAN;
    else                r.cls = NORMAL;
    return r;
  endfunction

  function automatic logic [63:0] pack(input lane_s1_t a);
    logic [10:0] rebias;
    logic [9:0]  frac;
    logic [63:0] r;
    rebias = a.mode ? 11'(REBIAS_B) : 11'(REBIAS_H);
    // Shift past the leading one so the hidden bit falls off the top.
    frac   = a.man << (a.lz + 4'd1);
    r      = {a.sign, rebias + {3'b000, a.exp}, a.man, 42'b0};
    case (a.cls)
      ZERO:    r = {a.sign, 63'b0};
      DENORM:  r = DENORM_FTZ ? {a.sign, 63'b0}
                               : {a.sign, rebias - {7'b0, a.lz}, frac, 42'b0};
      INF:     r = {a.sign, 11'h7FF, 52'b0};
      NAN:     r = {a.sign, 11'h7FF, 1'b1, a.man[8:0], 42'b0};
      default: ;
    endcase
    return r;
  endfunction

  assign s1_d       = classify(raw, mode);
  assign res        = pack(s1_q);
  assign denorm_hit = (s1_q.cls == DENORM);
  assign snan_hit   = (s1_q.cls == NAN) && !s1_q.man[9];

endmodule

// File: rtl/fpu_conv_pk_h2d.sv
// Packed FP16/BF16 -> FP64 converter, LANES wide; two register stages (beat in cycle n leaves in cycle n+2).
// Valid/ready: a stage advances when the next one is empty or draining; o_data holds while stalled.
module fpu_conv_pk_h2d
  import fpu_conv_pkg::*;
#(
  parameter int LANES      = 4,
  parameter bit DENORM_FTZ = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  fpu_conv_pk_h2d_if.slave bus
);

  lane_s1_t [LANES-1:0]  s1_d;
  lane_s1_t [LANES-1:0]  s1_q;
  logic [LANES-1:0]      dn_hit;
  logic [LANES-1:0]      sn_hit;
  logic [64*LANES-1:0]   res;
  logic [64*LANES-1:0]   o_data_q;
  logic [1:0]            flags_q;
  logic                  s1_v;
  logic                  s2_v;
  logic                  s2_free;
  logic                  in_rdy;
  logic                  accept;
  logic                  s1_move;

  assign s2_free = !s2_v || bus.o_ready;
  assign in_rdy  = !s1_v || s2_free;
  assign accept  = bus.i_valid && in_rdy;
  assign s1_move = s1_v && s2_free;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fpu_conv_lane_h2d #(.DENORM_FTZ(DENORM_FTZ)) u_lane (
      .raw        (bus.i_data[16*k +: 16]),
      .mode       (bus.i_mode),
      .s1_d       (s1_d[k]),
      .s1_q       (s1_q[k]),
      .res        (res[64*k +: 64]),
      .denorm_hit (dn_hit[k]),
      .snan_hit   (sn_hit[k])
    );
  end

  always_ff @(posedge clock) begin
    if (accept) s1_q <= s1_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      o_data_q <= '0;
      flags_q  <= 2'b00;
    end else begin
      if (in_rdy) s1_v <= bus.i_valid;
      if (s2_free) begin
        s2_v <= s1_v;
        if (s1_v) o_data_q <= res;
      end
      // A clear in the same cycle as a new event wins; that event is not recorded.
      if (bus.flags_clr) begin
        flags_q <= 2'b00;
      end else if (s1_move) begin
        flags_q[FLAG_DENORM]  <= flags_q[FLAG_DENORM]  | (|dn_hit);
        flags_q[FLAG_INVALID] <= flags_q[FLAG_INVALID] | (|sn_hit);
      end
    end
  end

  assign bus.i_ready = in_rdy;
  assign bus.o_valid = s2_v;
  assign bus.o_data  = o_data_q;
  assign bus.flags   = flags_q;

endmodule

// File: tb/tb_fpu_conv_pk_h2d.sv
// Directed bench for fpu_conv_pk_h2d (default and flush-to-zero builds side by side), plus
// a backpressure stream and an exhaustive 16-bit code sweep checked against an independent model.
module tb_fpu_conv_pk_h2d;

  localparam int LANES = 4;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  fpu_conv_pk_h2d_if #(.LANES(LANES)) bus0 ();
  fpu_conv_pk_h2d_if #(.LANES(LANES)) bus1 ();

  fpu_conv_pk_h2d #(.LANES(LANES), .DENORM_FTZ(1'b0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  fpu_conv_pk_h2d #(.LANES(LANES), .DENORM_FTZ(1'b1)) dut_ftz (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  assign bus1.i_valid   = bus0.i_valid;
  assign bus1.i_mode    = bus0.i_mode;
  assign bus1.i_data    = bus0.i_data;
  assign bus1.o_ready   = bus0.o_ready;
  assign bus1.flags_clr = bus0.flags_clr;

  logic [63:0] bp_data [8];
  logic        bp_mode [8];
  logic        bp_rdy  [8];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Reference conversion: unbiased exponent, bit-by-bit normalisation loop.
  function automatic logic [63:0] ref64(input logic [15:0] x, input logic md, input bit ftz);
    int          mb, bias, emax, e, ex;
    logic [63:0] m, frac;
    logic        s;
    s    = x[15];
    mb   = md ? 7 : 10;
    bias = md ? 127 : 15;
    emax = md ? 255 : 31;
    e    = md ? int'(x[14:7]) : int'(x[14:10]);
    m    = md ? 64'(x[6:0]) : 64'(x[9:0]);
    if (e == emax) begin
      if (m == 64'd0) return {s, 11'h7FF, 52'd0};
      frac = (m << (52 - mb)) | (64'd1 << 51);
      return {s, 11'h7FF, frac[51:0]};
    end
    if (e == 0 && m == 64'd0) return {s, 63'd0};
    if (e == 0) begin
      if (ftz) return {s, 63'd0};
      ex   = 1 - bias;
      frac = m;
      while (frac[mb] == 1'b0) begin
        frac = frac << 1;
        ex--;
      end
      frac[mb] = 1'b0;
      frac     = frac << (52 - mb);
      return {s, 11'(ex + 1023), frac[51:0]};
    end
    frac = m << (52 - mb);
    return {s, 11'(e - bias + 1023), frac[51:0]};
  endfunction

  function automatic logic [255:0] pack4(input logic [63:0] din, input logic md, input bit ftz);
    logic [255:0] r;
    for (int k = 0; k < 4; k++) r[64*k +: 64] = ref64(din[16*k +: 16], md, ftz);
    return r;
  endfunction

  task automatic send(input logic [63:0] data, input logic md);
    int w;
    bus0.i_data  = data;
    bus0.i_mode  = md;
    bus0.i_valid = 1'b1;
    w = 0;
    #1;
    while (!bus0.i_ready && w < 20) begin
      tick();
      #1;
      w++;
    end
    chk2("send_timeout", 2'(w >= 20), 2'b00);
    tick();
    bus0.i_valid = 1'b0;
  endtask

  // lat counts rising edges from the accept edge (inclusive) until o_valid is visible.
  task automatic recv(output logic [255:0] d0, output logic [255:0] d1, output int lat);
    lat = 1;
    while (!bus0.o_valid && lat < 20) begin
      tick();
      lat++;
    end
    d0 = bus0.o_data;
    d1 = bus1.o_data;
    tick();
  endtask

  task automatic stream(input int n_beats, input bit sweep);
    logic [255:0] q0[$];
    logic [255:0] q1[$];
    logic [255:0] held;
    logic [63:0]  din;
    logic         md;
    int           sent, got, occ, cyc, base;
    bit           acc, dlv, stall;
    sent = 0; got = 0; occ = 0; cyc = 0; stall = 0; held = '0; md = 1'b0; din = '0;
    while (got < n_beats && cyc < 3 * n_beats + 20) begin
      bus0.o_ready = sweep ? 1'b1 : ((cyc < 8) ? bp_rdy[cyc] : 1'b1);
      if (sent < n_beats) begin
        if (sweep) begin
          md   = (sent >= n_beats / 2);
          base = (sent % (n_beats / 2)) * 4;
          din  = {16'(base + 3), 16'(base + 2), 16'(base + 1), 16'(base)};
        end else begin
          din = bp_data[sent];
          md  = bp_mode[sent];
        end
        bus0.i_valid = 1'b1;
        bus0.i_data  = din;
        bus0.i_mode  = md;
      end else begin
        bus0.i_valid = 1'b0;
      end
      #1;
      chk2("strm_irdy", 2'(bus0.i_ready), 2'((occ < 2) || bus0.o_ready));
      if (stall) begin
        chk2("strm_hold_v", 2'(bus0.o_valid), 2'b01);
        chk("strm_hold_d", bus0.o_data, held);
      end
      dlv = bus0.o_valid && bus0.o_ready;
      acc = bus0.i_valid && bus0.i_ready;
      if (acc) begin
        q0.push_back(pack4(din, md, 1'b0));
        q1.push_back(pack4(din, md, 1'b1));
      end
      if (dlv) begin
        chk2("strm_expected", 2'(q0.size() > 1 || (q0.size() == 1 && !acc)), 2'b01);
        if (q0.size() > 0) chk("strm_data", bus0.o_data, q0.pop_front());
        if (q1.size() > 0) chk("strm_data_ftz", bus1.o_data, q1.pop_front());
      end
      occ  += (acc ? 1 : 0) - (dlv ? 1 : 0);
      stall = bus0.o_valid && !bus0.o_ready;
      held  = bus0.o_data;
      if (acc) sent++;
      if (dlv) got++;
      tick();
      cyc++;
    end
    chk2("strm_all_out", 2'(got == n_beats), 2'b01);
    bus0.i_valid = 1'b0;
    bus0.o_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] d0, d1;
    int           lat;

    bp_data[0] = 64'h3C00_0001_7C01_8400; bp_mode[0] = 1'b0;
    bp_data[1] = 64'h3F80_0001_7F81_C049; bp_mode[1] = 1'b1;
    bp_data[2] = 64'h03FF_7BFF_FE00_0000; bp_mode[2] = 1'b0;
    bp_data[3] = 64'h0040_8080_7FC0_4049; bp_mode[3] = 1'b1;
    bp_data[4] = 64'h1234_5678_9ABC_DEF0; bp_mode[4] = 1'b0;
    bp_data[5] = 64'h1234_5678_9ABC_DEF0; bp_mode[5] = 1'b1;
    bp_data[6] = 64'hFC00_8001_3555_0400; bp_mode[6] = 1'b0;
    bp_data[7] = 64'hFF80_807F_3E80_0000; bp_mode[7] = 1'b1;
    bp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    reset          = 1'b1;
    bus0.i_valid   = 1'b0;
    bus0.i_mode    = 1'b0;
    bus0.i_data    = '0;
    bus0.o_ready   = 1'b1;
    bus0.flags_clr = 1'b0;
    repeat (3) tick();
    chk2("rst_ovalid", 2'(bus0.o_valid), 2'b00);
    chk("rst_odata", bus0.o_data, '0);
    chk2("rst_flags", bus0.flags, 2'b00);
    reset = 1'b0;
    tick();
    chk2("rst_irdy", 2'(bus0.i_ready), 2'b01);

    // FP16 normal, negative, smallest denormal, infinity
    send(64'h7C00_0001_C000_3C00, 1'b0);
    recv(d0, d1, lat);
    chk2("t1_latency", 2'(lat), 2'd2);
    chk("t1_fp16", d0, {64'h7FF0000000000000, 64'h3E70000000000000,
                        64'hC000000000000000, 64'h3FF0000000000000});
    chk("t1_fp16_ftz", d1, {64'h7FF0000000000000, 64'h0000000000000000,
                            64'hC000000000000000, 64'h3FF0000000000000});
    chk2("t1_flags", bus0.flags, 2'b10);
    chk2("t1_flags_ftz", bus1.flags, 2'b10);

    // NaN quieting and invalid flag
    bus0.flags_clr = 1'b1; tick(); bus0.flags_clr = 1'b0;
    chk2("t2_clr", bus0.flags, 2'b00);
    send(64'h0000_FC00_7E00_7C01, 1'b0);
    recv(d0, d1, lat);
    chk("t2_snan", d0, {64'h0000000000000000, 64'hFFF0000000000000,
                        64'h7FF8000000000000, 64'h7FF8040000000000});
    chk2("t2_flags_snan", bus0.flags, 2'b01);
    bus0.flags_clr = 1'b1; tick(); bus0.flags_clr = 1'b0;
    chk2("t2_clr2", bus0.flags, 2'b00);
    send(64'hFE00_FE00_8400_FE00, 1'b0);
    recv(d0, d1, lat);
    chk("t2_qnan", d0, {64'hFFF8000000000000, 64'hFFF8000000000000,
                        64'hBF10000000000000, 64'hFFF8000000000000});
    chk2("t2_flags_qnan", bus0.flags, 2'b00);
    // clear lands on the same edge the sNaN beat moves into stage 2
    send(64'h0000_0000_0000_7C01, 1'b0);
    bus0.flags_clr = 1'b1; tick(); bus0.flags_clr = 1'b0;
    chk2("t2_clr_prio", bus0.flags, 2'b00);
    recv(d0, d1, lat);
    chk("t2_clr_beat", d0, {192'd0, 64'h7FF8040000000000});
    chk2("t2_clr_after", bus0.flags, 2'b00);

    // BF16
    send(64'h7F80_8000_0001_3F80, 1'b1);
    recv(d0, d1, lat);
    chk("t3_bf16", d0, {64'h7FF0000000000000, 64'h8000000000000000,
                        64'h37A0000000000000, 64'h3FF0000000000000});
    chk("t3_bf16_ftz", d1, {64'h7FF0000000000000, 64'h8000000000000000,
                            64'h0000000000000000, 64'h3FF0000000000000});
    chk2("t3_flags", bus0.flags, 2'b10);
    send(64'hFF80_0040_4049_7F81, 1'b1);
    recv(d0, d1, lat);
    chk("t3_bf16_b", d0, {64'hFFF0000000000000, 64'h3800000000000000,
                          64'h4009200000000000, 64'h7FF8200000000000});
    chk2("t3_flags_b", bus0.flags, 2'b11);

    // FP16 range edges; flush-to-zero build
    bus0.flags_clr = 1'b1; tick(); bus0.flags_clr = 1'b0;
    send(64'h0400_7BFF_03FF_8001, 1'b0);
    recv(d0, d1, lat);
    chk("t6_edges", d0, {64'h3F10000000000000, 64'h40EFFC0000000000,
                         64'h3F0FF80000000000, 64'hBE70000000000000});
    chk("t6_edges_ftz", d1, {64'h3F10000000000000, 64'h40EFFC0000000000,
                             64'h0000000000000000, 64'h8000000000000000});
    chk2("t6_flags_ftz", bus1.flags, 2'b10);

    // Backpressure with mixed modes
    stream(8, 1'b0);

    // Reset with two beats in flight
    bus0.flags_clr = 1'b1; tick(); bus0.flags_clr = 1'b0;
    bus0.o_ready = 1'b0;
    send(64'h0001_3C00_3C00_3C00, 1'b0);
    send(64'h4000_4000_4000_4000, 1'b0);
    chk2("t5_full_ovalid", 2'(bus0.o_valid), 2'b01);
    chk2("t5_full_irdy", 2'(bus0.i_ready), 2'b00);
    chk2("t5_full_flags", bus0.flags, 2'b10);
    reset = 1'b1; tick(); reset = 1'b0;
    bus0.o_ready = 1'b1;
    #1;
    chk2("t5_rst_ovalid", 2'(bus0.o_valid), 2'b00);
    chk2("t5_rst_flags", bus0.flags, 2'b00);
    chk("t5_rst_odata", bus0.o_data, '0);
    chk2("t5_rst_irdy", 2'(bus0.i_ready), 2'b01);
    tick();
    chk2("t5_quiet1", 2'(bus0.o_valid), 2'b00);
    tick();
    chk2("t5_quiet2", 2'(bus0.o_valid), 2'b00);
    send(64'hC000_3C00_0000_8000, 1'b0);
    recv(d0, d1, lat);
    chk2("t5_latency", 2'(lat), 2'd2);
    chk("t5_beat", d0, {64'hC000000000000000, 64'h3FF0000000000000,
                        64'h0000000000000000, 64'h8000000000000000});

    // Every 16-bit code in both formats, both builds
    bus0.flags_clr = 1'b1; tick(); bus0.flags_clr = 1'b0;
    stream(32768, 1'b1);
    chk2("sweep_flags", bus0.flags, 2'b11);
    chk2("sweep_flags_ftz", bus1.flags, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
